// File: rtl/round_access_ctrl.sv
// Consumer-side access controller for the round timer: sequences reload/enable,
// steps the Morse ROM address, judges player symbols and keeps score and misses.
module round_access_ctrl #(
    parameter int ADDR_W    = 5,
    parameter int MAX_MISS  = 3,
    parameter int SCORE_MAX = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sym_valid,
    input  logic              sym_match,
    input  logic              last_sym,
    input  logic              TimeOut,
    output logic              timer_enable,
    output logic              timer_reconfig,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [3:0]        score,
    output logic [1:0]        misses,
    output logic              win,
    output logic              lose
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PLAY,
        WIN,
        LOSE
    } state_t;

    localparam logic [1:0]        MISS_LIMIT = 2'(MAX_MISS);
    localparam logic [3:0]        SCORE_TOP  = 4'(SCORE_MAX);
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

    state_t state;

    // NOTE: the reset branch lives inside the clocked block, so reset is synchronous;
    // all state and outputs use non-blocking assignments so every output is registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            timer_enable   <= 1'b0;
            timer_reconfig <= 1'b0;
            rom_addr       <= '0;
            score          <= '0;
            misses         <= '0;
            win            <= 1'b0;
            lose           <= 1'b0;
        end else begin
            case (state)
                IDLE, WIN, LOSE: begin
                    if (start) begin
                        state          <= LOAD;
                        timer_reconfig <= 1'b1;
                        timer_enable   <= 1'b0;
                        misses         <= '0;
                        win            <= 1'b0;
                        lose           <= 1'b0;
                        // A lost game restarts from the first word with a clean score.
                        if (state == LOSE) begin
                            rom_addr <= '0;
                            score    <= '0;
                        end
                    end
                end

                LOAD: begin
                    state          <= PLAY;
                    timer_reconfig <= 1'b0;
                    timer_enable   <= 1'b1;
                    misses         <= '0;
                end

                PLAY: begin
                    if (TimeOut) begin
                        state        <= LOSE;
                        timer_enable <= 1'b0;
                        lose         <= 1'b1;
                    end else if (sym_valid && sym_match) begin
                        rom_addr <= rom_addr + ADDR_ONE;
                        if (last_sym) begin
                            state        <= WIN;
                            timer_enable <= 1'b0;
                            win          <= 1'b1;
                            if (score < SCORE_TOP) begin
                                score <= score + 4'd1;
                            end
                        end
                    end else if (sym_valid) begin
                        misses <= misses + 2'd1;
                        if (misses + 2'd1 == MISS_LIMIT) begin
                            state        <= LOSE;
                            timer_enable <= 1'b0;
                            lose         <= 1'b1;
                        end
                    end
                end

                default: begin
                    state          <= IDLE;
                    timer_enable   <= 1'b0;
                    timer_reconfig <= 1'b0;
                    win            <= 1'b0;
                    lose           <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_access_ctrl.sv
// Scoreboard bench for round_access_ctrl: a game-rule model predicts outputs per cycle,
// a separate monitor compares them against the DUT one cycle after each stimulus.
module tb_round_access_ctrl;

    localparam int AW        = 3;
    localparam int MAX_MISS  = 3;
    localparam int SCORE_MAX = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          sym_valid = 1'b0;
    logic          sym_match = 1'b0;
    logic          last_sym = 1'b0;
    logic          TimeOut = 1'b0;
    logic          timer_enable;
    logic          timer_reconfig;
    logic [AW-1:0] rom_addr;
    logic [3:0]    score;
    logic [1:0]    misses;
    logic          win;
    logic          lose;

    round_access_ctrl #(
        .ADDR_W   (AW),
        .MAX_MISS (MAX_MISS),
        .SCORE_MAX(SCORE_MAX)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .sym_valid     (sym_valid),
        .sym_match     (sym_match),
        .last_sym      (last_sym),
        .TimeOut       (TimeOut),
        .timer_enable  (timer_enable),
        .timer_reconfig(timer_reconfig),
        .rom_addr      (rom_addr),
        .score         (score),
        .misses        (misses),
        .win           (win),
        .lose          (lose)
    );

    always #5 clk = ~clk;

    // Predicted output set; the game mode is read off these observable flags.
    typedef struct {
        int en;
        int rc;
        int addr;
        int score;
        int misses;
        int win;
        int lose;
    } outs_t;

    outs_t model;
    outs_t exp_q[$];
    outs_t e;
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    endtask

    function automatic outs_t model_next(outs_t c, bit r, bit st, bit v, bit mt, bit l, bit t);
        outs_t n = c;
        if (!r) begin
            n = '{default: 0};
            return n;
        end
        if (c.rc != 0) begin
            n.rc = 0;
            n.en = 1;
            n.misses = 0;
        end else if (c.en != 0) begin
            if (t) begin
                n.en = 0;
                n.lose = 1;
            end else if (v && mt) begin
                n.addr = (c.addr + 1) % (1 << AW);
                if (l) begin
                    n.en = 0;
                    n.win = 1;
                    n.score = (c.score < SCORE_MAX) ? c.score + 1 : c.score;
                end
            end else if (v) begin
                n.misses = c.misses + 1;
                if (n.misses == MAX_MISS) begin
                    n.en = 0;
                    n.lose = 1;
                end
            end
        end else if (st) begin
            if (c.lose != 0) begin
                n.addr = 0;
                n.score = 0;
            end
            n.rc = 1;
            n.win = 0;
            n.lose = 0;
            n.misses = 0;
        end
        return n;
    endfunction

    // One stimulus cycle: drive at the falling edge, predict, enqueue the expectation.
    task automatic step(input bit r, input bit st, input bit v, input bit mt,
                        input bit l, input bit t);
        @(negedge clk);
        rst = r; start = st; sym_valid = v; sym_match = mt; last_sym = l; TimeOut = t;
        model = model_next(model, r, st, v, mt, l, t);
        exp_q.push_back(model);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares the DUT just after the edge that consumed each stimulus.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("timer_enable", int'(timer_enable), e.en);
            check("timer_reconfig", int'(timer_reconfig), e.rc);
            check("rom_addr", int'(rom_addr), e.addr);
            check("score", int'(score), e.score);
            check("misses", int'(misses), e.misses);
            check("win", int'(win), e.win);
            check("lose", int'(lose), e.lose);
        end
    end

    initial begin
        model = '{default: 0};

        // Reset, then start: one reconfig cycle followed by enable.
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1, 1);
        idle_cycles(2);
        step(1, 1, 0, 0, 0, 0);
        idle_cycles(2);

        // Three-symbol word won.
        step(1, 0, 1, 1, 0, 0);
        step(1, 0, 1, 1, 0, 0);
        step(1, 0, 1, 1, 1, 0);
        idle_cycles(2);

        // Three misses lose; the next start is a new game.
        step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 1, 0);
        step(1, 0, 1, 0, 0, 0);
        idle_cycles(2);
        step(1, 1, 0, 0, 0, 0);
        idle_cycles(2);

        // TimeOut beats a matching last symbol in the same cycle.
        step(1, 0, 1, 1, 1, 1);
        idle_cycles(1);

        // Ten straight wins: address wraps and score saturates.
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 0, 0, 0, 0);
            step(1, 0, 0, 0, 0, 0);
            step(1, 0, 1, 1, 1, 0);
        end
        idle_cycles(1);

        // Move to address 5 in one round with start ignored in PLAY, then reset mid-round.
        step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 1, 1, 1);
        step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 1, 1, 0, 0);
            step(1, 1, 0, 0, 0, 0);
        end
        step(0, 0, 0, 0, 0, 0);
        idle_cycles(2);

        // Randomized play.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 49) == 0));
        end

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
